// File: rtl/pdl_sched.sv
// Multi-channel pulse-delay scheduler: per-channel delay/width windows played
// out on a shared timebase after a synchronised trigger rising edge.
module pdl_sched #(
    parameter int unsigned N       = 32,
    parameter int unsigned OUT_NUM = 8,
    localparam int unsigned AW     = $clog2(OUT_NUM)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_wr,
    input  logic [1:0]         cfg_sel,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [N-1:0]       cfg_data,
    output logic               cfg_ready,
    input  logic               arm,
    input  logic               disarm,
    input  logic               trigger,
    output logic [OUT_NUM-1:0] pulse_out,
    output logic               busy,
    output logic               done,
    output logic               overrun
);

    localparam int unsigned TW = N + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       delay_q [OUT_NUM];
    logic [N-1:0]       width_q [OUT_NUM];
    logic [OUT_NUM-1:0] enable_q;
    logic               auto_rearm_q;
    logic               s1_q, s2_q;
    logic               rise;
    logic [TW-1:0]      t_q, t_d;
    logic [TW-1:0]      last_end_q, last_end_d;
    logic [TW-1:0]      win_end [OUT_NUM];
    logic [TW-1:0]      max_end;
    logic [OUT_NUM-1:0] live;
    logic [OUT_NUM-1:0] pulse_win;
    logic [OUT_NUM-1:0] pulse_d;
    logic               done_d;
    logic               overrun_d;
    logic               wr_ok;

    // Trigger synchroniser; rise is the first cycle s1 sees the trigger high
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= trigger;
            s2_q <= s1_q;
        end
    end

    assign rise  = s1_q & ~s2_q;
    assign wr_ok = cfg_wr && (state_q == IDLE);

    // Configuration bank; out-of-range channel indices match no entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < OUT_NUM; i++) begin
                delay_q[i] <= '0;
                width_q[i] <= '0;
            end
            enable_q     <= '0;
            auto_rearm_q <= 1'b0;
        end else if (wr_ok) begin
            case (cfg_sel)
                2'd0: begin
                    for (int i = 0; i < OUT_NUM; i++) begin
                        if (cfg_addr == AW'(i)) delay_q[i] <= cfg_data;
                    end
                end
                2'd1: begin
                    for (int i = 0; i < OUT_NUM; i++) begin
                        if (cfg_addr == AW'(i)) width_q[i] <= cfg_data;
                    end
                end
                2'd2:    enable_q     <= cfg_data[OUT_NUM-1:0];
                default: auto_rearm_q <= cfg_data[0];
            endcase
        end
    end

    // Per-channel window end (no wrap at N+1 bits) and live window decode
    always_comb begin
        live      = '0;
        pulse_win = '0;
        for (int i = 0; i < OUT_NUM; i++) begin
            win_end[i]   = TW'(delay_q[i]) + TW'(width_q[i]);
            live[i]      = enable_q[i] && (width_q[i] != '0);
            pulse_win[i] = live[i] && (t_q >= TW'(delay_q[i])) && (t_q < win_end[i]);
        end
    end

    // Latest window end among live channels, latched as last_end on arm
    always_comb begin
        max_end = '0;
        for (int i = 0; i < OUT_NUM; i++) begin
            if (live[i] && (win_end[i] > max_end)) max_end = win_end[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            t_q        <= '0;
            last_end_q <= '0;
            pulse_out  <= '0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            last_end_q <= last_end_d;
            pulse_out  <= pulse_d;
            done       <= done_d;
            overrun    <= overrun_d;
        end
    end

    // Next-state and next-output decode; disarm outranks everything else
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        last_end_d = last_end_q;
        pulse_d    = '0;
        done_d     = 1'b0;
        overrun_d  = overrun;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d    = ARMED;
                    overrun_d  = 1'b0;
                    last_end_d = max_end;
                end
            end
            ARMED: begin
                if (disarm) begin
                    state_d = IDLE;
                end else if (rise) begin
                    state_d = RUN;
                    t_d     = '0;
                end
            end
            RUN: begin
                if (disarm) begin
                    state_d = IDLE;
                end else begin
                    if (rise) overrun_d = 1'b1;
                    if (t_q == last_end_q) begin
                        done_d  = 1'b1;
                        state_d = auto_rearm_q ? ARMED : IDLE;
                    end else begin
                        t_d     = t_q + TW'(1);
                        pulse_d = pulse_win;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q == ARMED) || (state_q == RUN);

endmodule

// File: tb/tb_pdl_sched.sv
// Self-checking bench for pdl_sched: directed scenarios plus randomized runs
// compared against a cycle-window model derived from the timing rules.
module tb_pdl_sched;

    localparam int unsigned N       = 16;
    localparam int unsigned OUT_NUM = 6;
    localparam int unsigned AW      = $clog2(OUT_NUM);

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_wr;
    logic [1:0]         cfg_sel;
    logic [AW-1:0]      cfg_addr;
    logic [N-1:0]       cfg_data;
    logic               cfg_ready;
    logic               arm;
    logic               disarm;
    logic               trigger;
    logic [OUT_NUM-1:0] pulse_out;
    logic               busy;
    logic               done;
    logic               overrun;

    int vectors = 0;
    int fails   = 0;

    int                 m_delay [OUT_NUM];
    int                 m_width [OUT_NUM];
    logic [OUT_NUM-1:0] m_en;
    bit                 m_auto;
    bit                 m_idle;
    bit                 m_ovr;
    int                 m_le;

    pdl_sched #(.N(N), .OUT_NUM(OUT_NUM)) dut (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .arm(arm), .disarm(disarm), .trigger(trigger), .pulse_out(pulse_out),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < OUT_NUM; i++) begin
            m_delay[i] = 0;
            m_width[i] = 0;
        end
        m_en   = '0;
        m_auto = 1'b0;
        m_idle = 1'b1;
        m_ovr  = 1'b0;
        m_le   = 0;
    endtask

    task automatic cfg_write(input int sel, input int addr, input int data);
        cfg_wr   = 1'b1;
        cfg_sel  = 2'(sel);
        cfg_addr = AW'(addr);
        cfg_data = N'(data);
        tick();
        cfg_wr = 1'b0;
        if (m_idle) begin
            case (sel)
                0: if (addr < OUT_NUM) m_delay[addr] = data;
                1: if (addr < OUT_NUM) m_width[addr] = data;
                2: m_en = OUT_NUM'(data);
                default: m_auto = (data & 1) != 0;
            endcase
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        if (m_idle) begin
            m_le = 0;
            for (int i = 0; i < OUT_NUM; i++) begin
                if (m_en[i] && m_width[i] != 0 && m_delay[i] + m_width[i] > m_le)
                    m_le = m_delay[i] + m_width[i];
            end
            m_ovr  = 1'b0;
            m_idle = 1'b0;
        end
        check("arm_busy", 32'(busy), 32'(!m_idle));
        check("arm_ovr", 32'(overrun), 32'(m_ovr));
    endtask

    // One run from ARMED. m counts edges after E; a live channel is high for
    // m in [delay+1, delay+width], done appears at m = last_end+1.
    // kind: 0 none, 1 disarm before edge E+abort_m, 2 reset before edge E+abort_m.
    task automatic do_run(input int retrig, input int kind, input int abort_m);
        logic [OUT_NUM-1:0] exp;
        trigger = 1'b1;
        tick();
        check("run_a_busy", 32'(busy), 32'd1);
        tick();
        trigger = 1'b0;
        check("run_e_pulse", 32'(pulse_out), 32'd0);
        for (int m = 1; m <= m_le + 1; m++) begin
            if (kind == 1 && m == abort_m) disarm = 1'b1;
            if (kind == 2 && m == abort_m) reset = 1'b1;
            if (retrig > 0 && m == retrig) trigger = 1'b1;
            if (retrig > 0 && m == retrig + 2) trigger = 1'b0;
            tick();
            disarm = 1'b0;
            reset  = 1'b0;
            if (kind != 0 && m == abort_m) begin
                trigger = 1'b0;
                if (kind == 2) model_clear();
                m_idle = 1'b1;
                check("abort_pulse", 32'(pulse_out), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_ready", 32'(cfg_ready), 32'd1);
                check("abort_ovr", 32'(overrun), 32'(m_ovr));
                tick();
                check("abort_done2", 32'(done), 32'd0);
                return;
            end
            exp = '0;
            for (int i = 0; i < OUT_NUM; i++) begin
                if (m <= m_le && m_en[i] && m_width[i] != 0 &&
                    m >= m_delay[i] + 1 && m <= m_delay[i] + m_width[i])
                    exp[i] = 1'b1;
            end
            if (retrig > 0 && m == retrig + 1) m_ovr = 1'b1;
            check($sformatf("pulse_m%0d", m), 32'(pulse_out), 32'(exp));
            check($sformatf("done_m%0d", m), 32'(done), 32'(m == m_le + 1));
            check($sformatf("ovr_m%0d", m), 32'(overrun), 32'(m_ovr));
        end
        trigger = 1'b0;
        m_idle  = !m_auto;
        check("end_ready", 32'(cfg_ready), 32'(m_idle));
        check("end_busy", 32'(busy), 32'(!m_idle));
        tick();
        check("end_done_clr", 32'(done), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        cfg_wr   = 1'b1;
        cfg_sel  = 2'd1;
        cfg_addr = '0;
        cfg_data = N'(7);
        arm      = 1'b0;
        disarm   = 1'b0;
        trigger  = 1'b0;
        model_clear();
        tick();
        tick();
        check("rst_pulse", 32'(pulse_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset  = 1'b0;
        cfg_wr = 1'b0;
        tick();
        check("rst_ready", 32'(cfg_ready), 32'd1);

        // Write during reset was dropped: an armed run is done-only
        do_arm();
        do_run(0, 0, 0);

        // Basic delay/width
        cfg_write(0, 0, 5);
        cfg_write(1, 0, 3);
        cfg_write(0, 1, 0);
        cfg_write(1, 1, 1);
        cfg_write(2, 0, 3);
        do_arm();
        do_run(0, 0, 0);

        // Zero-width enabled and disabled channels give no output
        cfg_write(1, 2, 0);
        cfg_write(0, 3, 2);
        cfg_write(1, 3, 4);
        cfg_write(2, 0, 4);
        do_arm();
        do_run(0, 0, 0);

        // Overrun and auto re-arm
        cfg_write(3, 0, 1);
        cfg_write(0, 0, 10);
        cfg_write(1, 0, 10);
        cfg_write(2, 0, 1);
        do_arm();
        do_run(4, 0, 0);
        do_run(0, 0, 0);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        m_idle = 1'b1;
        check("ar_disarm_ready", 32'(cfg_ready), 32'd1);
        check("ar_ovr_sticky", 32'(overrun), 32'd1);
        do_arm();
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        m_idle = 1'b1;
        cfg_write(3, 0, 0);

        // Abort at T=6 while ch0 is high, then arm+disarm together in ARMED
        cfg_write(0, 0, 5);
        do_arm();
        do_run(0, 1, 7);
        do_arm();
        arm    = 1'b1;
        disarm = 1'b1;
        tick();
        arm    = 1'b0;
        disarm = 1'b0;
        m_idle = 1'b1;
        check("armdis_ready", 32'(cfg_ready), 32'd1);

        // Writes in ARMED and to out-of-range channels are dropped
        cfg_write(1, 0, 3);
        cfg_write(0, 6, 1);
        cfg_write(1, 7, 2);
        do_arm();
        cfg_write(0, 0, 99);
        do_run(0, 0, 0);

        // Rise while IDLE, and rise coincident with arm, are ignored
        trigger = 1'b1;
        tick();
        check("idle_rise_busy", 32'(busy), 32'd0);
        tick();
        trigger = 1'b0;
        tick();
        tick();
        trigger = 1'b1;
        tick();
        do_arm();
        tick();
        check("arm_rise_armed", 32'(cfg_ready), 32'd0);
        check("arm_rise_pulse", 32'(pulse_out), 32'd0);
        trigger = 1'b0;
        tick();
        tick();
        do_run(0, 0, 0);

        // Randomized configurations
        for (int it = 0; it < 25; it++) begin
            int kind;
            int am;
            for (int i = 0; i < OUT_NUM; i++) begin
                cfg_write(0, i, int'($urandom_range(0, 12)));
                cfg_write(1, i, int'($urandom_range(0, 6)));
            end
            cfg_write(2, 0, int'($urandom_range(0, (1 << OUT_NUM) - 1)));
            do_arm();
            kind = 0;
            am   = 0;
            if (m_le > 0 && $urandom_range(0, 3) == 0) begin
                kind = 1;
                am   = int'($urandom_range(1, m_le));
            end
            do_run(0, kind, am);
        end

        // Reset mid-run clears everything; the next run is done-only
        cfg_write(0, 0, 3);
        cfg_write(1, 0, 5);
        cfg_write(2, 0, 1);
        do_arm();
        do_run(0, 2, 4);
        do_arm();
        do_run(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
